// File: rtl/m65c02_bus_ctrl_pkg.sv
// Shared encodings for the M65C02 bus controller: core IO_Op codes,
// microcycle numbers and the sequencer state type.
package m65c02_bus_pkg;

  localparam logic [1:0] IO_OP_NONE  = 2'b00;
  localparam logic [1:0] IO_OP_WRITE = 2'b01;
  localparam logic [1:0] IO_OP_READ  = 2'b10;
  localparam logic [1:0] IO_OP_FETCH = 2'b11;

  localparam logic [2:0] MC_SETUP  = 3'd6;
  localparam logic [2:0] MC_ACCESS = 3'd7;
  localparam logic [2:0] MC_END    = 3'd5;
  localparam logic [2:0] MC_IDLE   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } bus_state_t;

  function automatic logic is_read_op(input logic [1:0] op);
    return (op == IO_OP_READ) || (op == IO_OP_FETCH);
  endfunction

endpackage

// File: rtl/m65c02_bus_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder; multi flags more than one request.
module bus_prio_enc #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic             multi
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    multi = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i]) begin
        if (valid) begin
          multi = 1'b1;
        end else begin
          idx   = IDX_W'(i);
          valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/m65c02_bus_ctrl.sv
// Microcycle-aware bus sequencer between the M65C02 core and N slaves.
// Optional write/read trace of one address when BUS_TRACE_EN is defined.
module m65c02_bus_ctrl
  import m65c02_bus_pkg::*;
#(
  parameter int unsigned       NUM_SLAVES    = 4,
  parameter int unsigned       DATA_W        = 8,
  parameter int unsigned       WAIT_W        = 4,
  parameter logic [DATA_W-1:0] UNMAPPED_DATA = 8'hFF,
  parameter logic [DATA_W-1:0] RESET_DATA    = 8'hEA,
  parameter logic [15:0]       TRACE_ADDR    = 16'h0010
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [15:0]                  cpu_addr,
  input  logic [DATA_W-1:0]            cpu_do,
  input  logic [1:0]                   cpu_io_op,
  input  logic [2:0]                   cpu_mc,
  output logic [DATA_W-1:0]            cpu_di,
  output logic                         cpu_wait,
  input  logic [NUM_SLAVES-1:0]        cs_vec,
  input  logic [NUM_SLAVES*WAIT_W-1:0] wait_cfg,
  input  logic [NUM_SLAVES*DATA_W-1:0] rdata_flat,
  output logic [NUM_SLAVES-1:0]        slave_we,
  output logic [NUM_SLAVES-1:0]        slave_re,
  output logic [DATA_W-1:0]            wdata,
  output logic                         bus_err
`ifdef BUS_TRACE_EN
  ,
  output logic                         trace_hit,
  output logic [DATA_W-1:0]            trace_wdata,
  output logic [DATA_W-1:0]            trace_rdata,
  output logic                         trace_match
`endif
);

  localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  bus_state_t state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  valid_q, valid_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]     di_q, di_d;
  logic [NUM_SLAVES-1:0] re_q, re_d;
  logic                  err_q, err_d;

  logic [SEL_W-1:0]  enc_idx;
  logic              enc_valid, enc_multi;
  logic              start, rd_capture;
  logic [WAIT_W-1:0] wait_sel;
  logic [DATA_W-1:0] rdata_sel;

  bus_prio_enc #(.N(NUM_SLAVES), .IDX_W(SEL_W)) u_prio_enc (
    .req   (cs_vec),
    .idx   (enc_idx),
    .valid (enc_valid),
    .multi (enc_multi)
  );

  assign start      = (cpu_mc == MC_SETUP) && (cpu_io_op != IO_OP_NONE);
  assign rd_capture = (state_q == ST_DONE) && (cpu_mc == MC_END) && is_read_op(op_q);
  assign wait_sel   = wait_cfg[enc_idx*WAIT_W +: WAIT_W];
  assign rdata_sel  = rdata_flat[sel_q*DATA_W +: DATA_W];

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    op_d     = op_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    di_d     = di_q;
    re_d     = '0;
    err_d    = err_q;
    slave_we = '0;
    cpu_wait = 1'b0;

    // SETUP already counts as the first wait cycle, so the counter is
    // decremented on leaving it and DONE is reached after exactly N waits.
    unique case (state_q)
      ST_IDLE: ;
      ST_SETUP: begin
        if ((op_q == IO_OP_WRITE) && valid_q) slave_we[sel_q] = 1'b1;
        cpu_wait = (cnt_q != '0);
        if (cnt_q > WAIT_W'(1)) begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q - WAIT_W'(1);
        end else begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        cpu_wait = 1'b1;
        if (cnt_q > WAIT_W'(1)) begin
          cnt_d = cnt_q - WAIT_W'(1);
        end else begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        if (cpu_mc == MC_END) begin
          if (rd_capture) begin
            di_d = valid_q ? rdata_sel : UNMAPPED_DATA;
            if (valid_q) re_d[sel_q] = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new access always wins; one arriving mid-access is a protocol error.
    if (start) begin
      if (state_q != ST_IDLE) err_d = 1'b1;
      if (enc_multi) err_d = 1'b1;
      state_d = ST_SETUP;
      sel_d   = enc_idx;
      valid_d = enc_valid;
      op_d    = cpu_io_op;
      wdata_d = cpu_do;
      cnt_d   = enc_valid ? wait_sel : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      valid_q <= 1'b0;
      op_q    <= IO_OP_NONE;
      wdata_q <= '0;
      cnt_q   <= '0;
      di_q    <= RESET_DATA;
      re_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      di_q    <= di_d;
      re_q    <= re_d;
      err_q   <= err_d;
    end
  end

  assign cpu_di   = di_q;
  assign slave_re = re_q;
  assign wdata    = wdata_q;
  assign bus_err  = err_q;

`ifdef BUS_TRACE_EN
  logic              tsel_q, tsel_d;
  logic              thit_q, thit_d;
  logic [DATA_W-1:0] twdata_q, twdata_d;
  logic [DATA_W-1:0] trdata_q, trdata_d;

  always_comb begin
    tsel_d   = tsel_q;
    thit_d   = thit_q;
    twdata_d = twdata_q;
    trdata_d = trdata_q;
    if (start) begin
      tsel_d = (cpu_addr == TRACE_ADDR);
      if ((cpu_io_op == IO_OP_WRITE) && enc_valid && (cpu_addr == TRACE_ADDR)) begin
        thit_d   = 1'b1;
        twdata_d = cpu_do;
      end
    end
    if (rd_capture && tsel_q) trdata_d = di_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tsel_q   <= 1'b0;
      thit_q   <= 1'b0;
      twdata_q <= '0;
      trdata_q <= '0;
    end else begin
      tsel_q   <= tsel_d;
      thit_q   <= thit_d;
      twdata_q <= twdata_d;
      trdata_q <= trdata_d;
    end
  end

  assign trace_hit   = thit_q;
  assign trace_wdata = twdata_q;
  assign trace_rdata = trdata_q;
  assign trace_match = (twdata_q == trdata_q);
`endif

  logic unused_ok;
  assign unused_ok = ^{MC_ACCESS, MC_IDLE
`ifndef BUS_TRACE_EN
                       , cpu_addr, TRACE_ADDR
`endif
                      };

endmodule

// File: tb/tb_m65c02_bus_ctrl.sv
// Directed bench for m65c02_bus_ctrl: each access pushes its expected
// outcome to a scoreboard that is popped once the access has completed.
module tb_m65c02_bus_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_do;
  logic [1:0]  cpu_io_op;
  logic [2:0]  cpu_mc;
  logic [7:0]  cpu_di;
  logic        cpu_wait;
  logic [3:0]  cs_vec;
  logic [15:0] wait_cfg;
  logic [31:0] rdata_flat;
  logic [3:0]  slave_we;
  logic [3:0]  slave_re;
  logic [7:0]  wdata;
  logic        bus_err;
`ifdef BUS_TRACE_EN
  logic        trace_hit;
  logic [7:0]  trace_wdata;
  logic [7:0]  trace_rdata;
  logic        trace_match;
`endif

  m65c02_bus_ctrl #(
    .NUM_SLAVES(4),
    .DATA_W(8),
    .WAIT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cpu_addr(cpu_addr),
    .cpu_do(cpu_do),
    .cpu_io_op(cpu_io_op),
    .cpu_mc(cpu_mc),
    .cpu_di(cpu_di),
    .cpu_wait(cpu_wait),
    .cs_vec(cs_vec),
    .wait_cfg(wait_cfg),
    .rdata_flat(rdata_flat),
    .slave_we(slave_we),
    .slave_re(slave_re),
    .wdata(wdata),
    .bus_err(bus_err)
`ifdef BUS_TRACE_EN
    ,
    .trace_hit(trace_hit),
    .trace_wdata(trace_wdata),
    .trace_rdata(trace_rdata),
    .trace_match(trace_match)
`endif
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    logic [7:0]  di;
    logic [3:0]  we;
    logic [7:0]  wd;
    logic [3:0]  re;
    int unsigned wt;
    logic        err;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  int unsigned obs_we_cnt, obs_re_cnt, obs_wait;
  logic [3:0]  obs_we_mask, obs_re_mask;
  logic [7:0]  obs_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_acc(input logic [7:0] di, input logic [3:0] we, input logic [7:0] wd,
                            input logic [3:0] re, input int unsigned wt, input logic err);
    exp_t e;
    e.di = di; e.we = we; e.wd = wd; e.re = re; e.wt = wt; e.err = err;
    sb.push_back(e);
  endtask

  task automatic sample();
    if (slave_we != 4'b0) begin
      obs_we_cnt++;
      obs_wd = wdata;
    end
    obs_we_mask |= slave_we;
    if (slave_re != 4'b0) obs_re_cnt++;
    obs_re_mask |= slave_re;
    if (cpu_wait) obs_wait++;
  endtask

  task automatic idle_bus();
    cpu_mc    = 3'd4;
    cpu_io_op = 2'b00;
  endtask

  // Core model: MC=6, then MC=7 held while Wait is high, then MC=5, MC=4.
  task automatic do_access(input string tag, input logic [1:0] op, input logic [15:0] addr,
                           input logic [7:0] dout, input logic [3:0] cs,
                           input logic [15:0] wcfg, input logic [31:0] rd);
    exp_t        e;
    logic        w;
    int unsigned guard;
    obs_we_cnt = 0; obs_re_cnt = 0; obs_wait = 0;
    obs_we_mask = '0; obs_re_mask = '0; obs_wd = '0;
    cpu_addr = addr; cpu_do = dout; cpu_io_op = op; cpu_mc = 3'd6;
    cs_vec = cs; wait_cfg = wcfg; rdata_flat = rd;
    @(posedge clk); #1;
    cpu_mc   = 3'd7;
    cs_vec   = 4'($urandom);
    wait_cfg = 16'($urandom);
    guard = 0;
    do begin
      sample();
      w = cpu_wait;
      @(posedge clk); #1;
      guard++;
    end while (w && guard < 40);
    chk({tag, "_wait_bound"}, {31'b0, w}, 32'd0);
    cpu_mc = 3'd5;
    sample();
    @(posedge clk); #1;
    idle_bus();
    sample();
    e.di = cpu_di;
    @(posedge clk); #1;
    sample();
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp_t x;
      x = sb.pop_front();
      chk({tag, "_di"}, {24'b0, e.di}, {24'b0, x.di});
      chk({tag, "_we_mask"}, {28'b0, obs_we_mask}, {28'b0, x.we});
      chk({tag, "_we_cnt"}, obs_we_cnt, (x.we != 4'b0) ? 32'd1 : 32'd0);
      if (x.we != 4'b0) chk({tag, "_wdata"}, {24'b0, obs_wd}, {24'b0, x.wd});
      chk({tag, "_re_mask"}, {28'b0, obs_re_mask}, {28'b0, x.re});
      chk({tag, "_re_cnt"}, obs_re_cnt, (x.re != 4'b0) ? 32'd1 : 32'd0);
      chk({tag, "_wait_cycles"}, obs_wait, x.wt);
      chk({tag, "_bus_err"}, {31'b0, bus_err}, {31'b0, x.err});
    end
  endtask

  task automatic reset_pulse(input int unsigned cycles);
    rst_n = 1'b0;
    idle_bus();
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; cpu_addr = '0; cpu_do = '0; cs_vec = '0; wait_cfg = '0; rdata_flat = '0;
    idle_bus();
    reset_pulse(3);
    chk("rst_cpu_di", {24'b0, cpu_di}, 32'hEA);
    chk("rst_cpu_wait", {31'b0, cpu_wait}, 32'd0);
    chk("rst_slave_we", {28'b0, slave_we}, 32'd0);
    chk("rst_slave_re", {28'b0, slave_re}, 32'd0);
    chk("rst_wdata", {24'b0, wdata}, 32'd0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    expect_acc(8'h5A, 4'b0000, 8'h00, 4'b0001, 0, 1'b0);
    do_access("rd_s0", 2'b10, 16'h1234, 8'h00, 4'b0001, 16'h7530, 32'h4433_225A);

    expect_acc(8'h5A, 4'b0010, 8'hC3, 4'b0000, 3, 1'b0);
    do_access("wr_s1", 2'b01, 16'h2000, 8'hC3, 4'b0010, 16'h7531, 32'h4433_2211);

    expect_acc(8'hFF, 4'b0000, 8'h00, 4'b0000, 0, 1'b0);
    do_access("rd_unmapped", 2'b10, 16'hF000, 8'h00, 4'b0000, 16'h7531, 32'h4433_2211);

    expect_acc(8'h11, 4'b0000, 8'h00, 4'b0010, 0, 1'b1);
    do_access("rd_multi_cs", 2'b10, 16'h3000, 8'h00, 4'b0110, 16'h0200, 32'h3322_1100);

    expect_acc(8'h11, 4'b1000, 8'h9D, 4'b0000, 1, 1'b1);
    do_access("wr_s3_sticky", 2'b01, 16'h8000, 8'h9D, 4'b1000, 16'h1000, 32'h3322_1100);

    expect_acc(8'h77, 4'b0000, 8'h00, 4'b0100, 2, 1'b1);
    do_access("fetch_s2", 2'b11, 16'hC000, 8'h00, 4'b0100, 16'h0200, 32'h0077_0000);

    // Reset in the middle of a 7-cycle wait.
    cpu_addr = 16'h0100; cpu_io_op = 2'b10; cpu_mc = 3'd6;
    cs_vec = 4'b0001; wait_cfg = 16'h0007; rdata_flat = 32'h0000_00AB;
    @(posedge clk); #1;
    cpu_mc = 3'd7;
    chk("midwait_wait_hi", {31'b0, cpu_wait}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("midwait_still_hi", {31'b0, cpu_wait}, 32'd1);
    reset_pulse(1);
    chk("midwait_rst_wait", {31'b0, cpu_wait}, 32'd0);
    chk("midwait_rst_di", {24'b0, cpu_di}, 32'hEA);
    chk("midwait_rst_err", {31'b0, bus_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midwait_no_re", {28'b0, slave_re}, 32'd0);
    chk("midwait_idle_wait", {31'b0, cpu_wait}, 32'd0);

    expect_acc(8'h3C, 4'b0000, 8'h00, 4'b0001, 1, 1'b0);
    do_access("rd_after_rst", 2'b10, 16'h0200, 8'h00, 4'b0001, 16'h0001, 32'h0000_003C);

    // New access issued while a 5-cycle read is still waiting.
    cpu_addr = 16'h0300; cpu_io_op = 2'b10; cpu_mc = 3'd6;
    cs_vec = 4'b0001; wait_cfg = 16'h0005; rdata_flat = 32'h0000_0066;
    @(posedge clk); #1;
    cpu_mc = 3'd7;
    repeat (2) @(posedge clk);
    #1;
    expect_acc(8'h3C, 4'b0010, 8'hB7, 4'b0000, 0, 1'b1);
    do_access("abort_wr_s1", 2'b01, 16'h2100, 8'hB7, 4'b0010, 16'h0000, 32'h0000_0066);

`ifdef BUS_TRACE_EN
    reset_pulse(2);
    chk("trace_rst_hit", {31'b0, trace_hit}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_acc(8'hEA, 4'b0001, 8'h42, 4'b0000, 0, 1'b0);
    do_access("trace_wr", 2'b01, 16'h0010, 8'h42, 4'b0001, 16'h0000, 32'h0000_0000);
    chk("trace_hit", {31'b0, trace_hit}, 32'd1);
    chk("trace_wdata", {24'b0, trace_wdata}, 32'h42);
    expect_acc(8'h42, 4'b0000, 8'h00, 4'b0001, 0, 1'b0);
    do_access("trace_rd_same", 2'b10, 16'h0010, 8'h00, 4'b0001, 16'h0000, 32'h0000_0042);
    chk("trace_match_hi", {31'b0, trace_match}, 32'd1);
    expect_acc(8'h00, 4'b0000, 8'h00, 4'b0001, 0, 1'b0);
    do_access("trace_rd_diff", 2'b10, 16'h0010, 8'h00, 4'b0001, 16'h0000, 32'h0000_0000);
    chk("trace_match_lo", {31'b0, trace_match}, 32'd0);
    chk("trace_rdata", {24'b0, trace_rdata}, 32'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
